// File: rtl/mc_control_fsm.sv
// Multicycle RISC-V control unit: Moore FSM sequencing fetch, decode, execute,
// memory and writeback. Outputs are forced low while rst is high.
//
// state      | meaning
// -----------+---------------------------------------------------
// FETCH      | read instruction at PC, PC <= PC + 4
// DECODE     | decode opcode, ALUOut <= oldPC + imm (branch/jal target)
// EXEC_R     | rs1 op rs2
// EXEC_I     | rs1 op imm
// MEM_ADDR   | rs1 + imm for load/store
// MEM_READ   | read data memory at computed address
// MEM_WB     | write loaded data to rd
// MEM_WRITE  | write rs2 to data memory
// BRANCH     | compare rs1/rs2, PC <= target if taken
// JAL        | PC <= target, ALUOut <= oldPC + 4
// JALR       | PC <= rs1 + imm
// JALR_LINK  | ALUOut <= oldPC + 4
// ALU_WB     | write ALUOut to rd
// LUI        | write extended immediate to rd
module mc_control_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       neg,
    output logic [2:0] imm_src,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       adr_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] alu_op,
    output logic       instr_done,
    output logic       illegal
);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_EXEC_R    = 4'd2,
        S_EXEC_I    = 4'd3,
        S_MEM_ADDR  = 4'd4,
        S_MEM_READ  = 4'd5,
        S_MEM_WB    = 4'd6,
        S_MEM_WRITE = 4'd7,
        S_BRANCH    = 4'd8,
        S_JAL       = 4'd9,
        S_JALR      = 4'd10,
        S_JALR_LINK = 4'd11,
        S_ALU_WB    = 4'd12,
        S_LUI       = 4'd13
    } state_t;

    state_t state;
    state_t state_next;
    logic   taken;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= state_next;
    end

    always_comb begin
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = ~zero;
            3'b100:  taken = neg;
            3'b101:  taken = ~neg;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_next = S_FETCH;
        imm_src    = 3'd0;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 2'd0;
        alu_src_b  = 2'd0;
        result_src = 2'd0;
        alu_op     = 2'd0;
        instr_done = 1'b0;
        illegal    = 1'b0;

        case (state)
            S_FETCH: begin
                ir_write   = 1'b1;
                alu_src_b  = 2'd2;
                result_src = 2'd2;
                pc_write   = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd1;
                case (opcode)
                    OP_R:    state_next = S_EXEC_R;
                    OP_IALU: state_next = S_EXEC_I;
                    OP_LW:   state_next = S_MEM_ADDR;
                    OP_SW:   begin imm_src = 3'd1; state_next = S_MEM_ADDR; end
                    OP_B:    begin imm_src = 3'd2; state_next = S_BRANCH;   end
                    OP_JAL:  begin imm_src = 3'd4; state_next = S_JAL;      end
                    OP_JALR: state_next = S_JALR;
                    OP_LUI:  begin imm_src = 3'd3; state_next = S_LUI;      end
                    default: illegal = 1'b1;
                endcase
            end
            S_EXEC_R: begin
                alu_src_a  = 2'd2;
                alu_op     = 2'd2;
                state_next = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a  = 2'd2;
                alu_src_b  = 2'd1;
                alu_op     = 2'd2;
                state_next = S_ALU_WB;
            end
            S_MEM_ADDR: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd1;
                // opcode comes straight from the IR, stable for the whole instruction
                if (opcode == OP_SW) begin
                    imm_src    = 3'd1;
                    state_next = S_MEM_WRITE;
                end else begin
                    state_next = S_MEM_READ;
                end
            end
            S_MEM_READ: begin
                adr_src    = 1'b1;
                state_next = S_MEM_WB;
            end
            S_MEM_WB: begin
                result_src = 2'd1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                adr_src    = 1'b1;
                mem_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 2'd2;
                alu_op     = 2'd1;
                imm_src    = 3'd2;
                pc_write   = taken;
                instr_done = 1'b1;
            end
            S_JAL: begin
                alu_src_a  = 2'd1;
                alu_src_b  = 2'd2;
                pc_write   = 1'b1;
                state_next = S_ALU_WB;
            end
            S_JALR: begin
                alu_src_a  = 2'd2;
                alu_src_b  = 2'd1;
                result_src = 2'd2;
                pc_write   = 1'b1;
                state_next = S_JALR_LINK;
            end
            S_JALR_LINK: begin
                alu_src_a  = 2'd1;
                alu_src_b  = 2'd2;
                state_next = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_LUI: begin
                imm_src    = 3'd3;
                result_src = 2'd3;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            default: state_next = S_FETCH;
        endcase

        // reset silences every output immediately, independent of the clock
        if (rst) begin
            imm_src    = 3'd0;
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            adr_src    = 1'b0;
            alu_src_a  = 2'd0;
            alu_src_b  = 2'd0;
            result_src = 2'd0;
            alu_op     = 2'd0;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port opcode, input, 7, inst[6:0] of the instruction register.
REQ-004 SHALL have port funct3, input, 3, inst[14:12].
REQ-005 SHALL have ports zero and neg, input, 1 each, ALU result flags, valid in the same cycle.
REQ-006 SHALL have port imm_src, output, 3, immediate-extender format: 0=I, 1=S, 2=SB, 3=U, 4=UJ.
REQ-007 SHALL have ports pc_write, ir_write, mem_write, reg_write, adr_src, output, 1 each; adr_src 0=PC, 1=result.
REQ-008 SHALL have ports alu_src_a, alu_src_b, result_src, alu_op, output, 2 each:
- alu_src_a: 0=PC, 1=oldPC, 2=rs1.
- alu_src_b: 0=rs2, 1=extended imm, 2=const 4.
- result_src: 0=ALUOut reg, 1=mem data, 2=ALU direct, 3=extended imm.
- alu_op: 0=add, 1=sub, 2=funct decode.
REQ-009 SHALL have ports instr_done and illegal, output, 1 each, single-cycle pulses.

Function
REQ-010 SHALL be a Moore FSM; outputs are functions of the state and, in BRANCH only, of funct3/zero/neg; any output not listed for a state is 0.
REQ-011 SHALL decode opcodes: R=0110011, IALU=0010011, LW=0000011, SW=0100011, B=1100011, JAL=1101111, JALR=1100111, LUI=0110111.
REQ-012 FETCH SHALL drive adr_src=0, ir_write=1, a=0, b=2, alu_op=0, result_src=2, pc_write=1; next state is DECODE.
REQ-013 DECODE SHALL drive a=1, b=1, alu_op=0.
- imm_src: B→2, JAL→4, LUI→3, SW→1, others→0.
- Next state: R→EXEC_R, IALU→EXEC_I, LW/SW→MEM_ADDR, B→BRANCH, JAL→JAL, JALR→JALR, LUI→LUI.
REQ-014 In DECODE, any other opcode SHALL assert illegal=1 and return to FETCH with no write strobe.
REQ-015 EXEC_R SHALL drive a=2, b=0, alu_op=2, then go to ALU_WB; EXEC_I SHALL drive a=2, b=1, imm_src=0, alu_op=2, then go to ALU_WB.
REQ-016 MEM_ADDR SHALL drive a=2, b=1, alu_op=0, with imm_src=1 for SW and 0 for LW; next state is MEM_WRITE for SW and MEM_READ for LW.
REQ-017 MEM_READ SHALL drive adr_src=1, result_src=0, then go to MEM_WB; MEM_WB SHALL drive result_src=1, reg_write=1, instr_done=1, then go to FETCH.
REQ-018 MEM_WRITE SHALL drive adr_src=1, result_src=0, mem_write=1, instr_done=1, then go to FETCH.
REQ-019 BRANCH SHALL drive a=2, b=0, alu_op=1, result_src=0, imm_src=2, instr_done=1, then go to FETCH.
- pc_write=taken, where taken is: funct3 000→zero, 001→!zero, 100→neg, 101→!neg.
- Any other funct3 SHALL give pc_write=0.
REQ-020 JAL SHALL drive a=1, b=2, alu_op=0, result_src=0, pc_write=1, then go to ALU_WB.
REQ-021 JALR SHALL drive a=2, b=1, imm_src=0, alu_op=0, result_src=2, pc_write=1, then go to JALR_LINK.
REQ-022 JALR_LINK SHALL drive a=1, b=2, alu_op=0, then go to ALU_WB.
REQ-023 ALU_WB SHALL drive result_src=0, reg_write=1, instr_done=1, then go to FETCH.
REQ-024 LUI SHALL drive imm_src=3, result_src=3, reg_write=1, instr_done=1, then go to FETCH.
REQ-025 Cycles per instruction, FETCH through the done state, SHALL be: R/IALU 4, LW 5, SW 4, B 3, JAL 4, JALR 5, LUI 3.
REQ-026 Every state SHALL assert at most one of pc_write or reg_write together with mem_write; mem_write and reg_write SHALL never both be 1.
REQ-027 Unreachable state encodings SHALL go to FETCH on the next edge with all outputs 0.

Reset
REQ-028 rst=1 SHALL immediately set state=FETCH and force every output to 0 regardless of clk, including mid-instruction.
REQ-029 After rst falls, the first rising edge SHALL be a FETCH cycle with FETCH outputs visible from deassertion.

Verification
REQ-030 Reset, then R opcode 0110011 → states FETCH, DECODE, EXEC_R, ALU_WB; reg_write=1 only in cycle 4; instr_done pulses once.
REQ-031 LW 0000011 → 5 cycles; MEM_ADDR imm_src=0; MEM_READ adr_src=1; MEM_WB result_src=1, reg_write=1. SW 0100011 → imm_src=1, mem_write=1 in cycle 4 only.
REQ-032 B with funct3=000 at zero=1 → pc_write=1 in cycle 3; same with zero=0 → pc_write=0; funct3=101 with neg=0 → pc_write=1; funct3=010 → pc_write=0.
REQ-033 JAL → imm_src=4 in DECODE, 4 cycles. JALR → 5 cycles, pc_write in JALR state, reg_write in ALU_WB. LUI → imm_src=3, result_src=3, 3 cycles.
REQ-034 opcode 1111111 → illegal=1 in DECODE, next cycle FETCH, no write strobes.
REQ-035 rst asserted mid-MEM_READ between edges → all outputs 0 at once; after release, FETCH with ir_write=1.
